lcd_char_rx: RTL and testbench

LCD_CHAR_RX -- requirements
Module: lcd_char_rx

---
 rtl/lcd_char_rx.sv | 185 ++++++++++++++++++
 tb/tb_lcd_char_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_rx.sv
// Snoops a write-only HD44780-style LCD bus into a 2x16 character shadow; command pulse 3-4 clks after E falls, BUSY drops strobes.
// Optional sticky OVERRUN on strobe-while-busy is built when LCD_RX_OVERRUN_EN is defined; otherwise OVERRUN is tied low.
module lcd_char_rx #(
    parameter int BUSY_CYCLES = 40
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic       CMD_VALID,
    output logic       CMD_RS,
    output logic [7:0] CMD_CODE,
    output logic       BUSY,
    output logic       DISP_ON,
    output logic [6:0] CUR_ADDR,
    output logic       OVERRUN
);

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } lcd_bus_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    lcd_bus_t   sync1, sync2, sync3;
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       inc;
    logic       strobe, accept, clear_done;
    logic [7:0] shadow [32];
    logic       mem_we;
    logic [4:0] mem_idx;
    logic [7:0] mem_wdat;

    // sync3 holds the last E=1 sample when the falling edge is seen in sync2
    always_ff @(posedge CLK) begin
        if (RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= '{e: LCD_E, rs: LCD_RS, rw: LCD_RW, dat: LCD_DATA};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign strobe     = sync3.e & ~sync2.e;
    assign BUSY       = (state != IDLE);
    assign accept     = strobe & ~BUSY & ~sync3.rw;
    assign clear_done = (state == CLEAR) && (cnt == 8'd31);

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!sync3.rs && sync3.dat == 8'h01) begin
                        state_nxt = CLEAR;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = EXEC;
                        cnt_nxt   = 8'(BUSY_CYCLES - 1);
                    end
                end
            end
            EXEC: begin
                if (cnt == 8'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            CLEAR: begin
                if (cnt == 8'd31) state_nxt = IDLE;
                else              cnt_nxt   = cnt + 8'd1;
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Off-map addresses snap to the next legal address in the step direction
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a <= 7'h26)      r = a + 7'd1;
            else if (a <= 7'h3F) r = 7'h40;
            else if (a <= 7'h66) r = a + 7'd1;
            else                 r = 7'h00;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a <= 7'h28) r = a - 7'd1;
            else if (a <= 7'h40) r = 7'h27;
            else if (a <= 7'h68) r = a - 7'd1;
            else                 r = 7'h67;
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            CUR_ADDR  <= '0;
            inc       <= 1'b1;
            DISP_ON   <= 1'b0;
            CMD_VALID <= 1'b0;
            CMD_RS    <= 1'b0;
            CMD_CODE  <= '0;
        end else begin
            CMD_VALID <= accept;
            if (accept) begin
                CMD_RS   <= sync3.rs;
                CMD_CODE <= sync3.dat;
            end
            if (clear_done) begin
                CUR_ADDR <= '0;
                inc      <= 1'b1;
            end else if (accept) begin
                if (sync3.rs) begin
                    CUR_ADDR <= addr_step(CUR_ADDR, inc);
                end else begin
                    casez (sync3.dat)
                        8'b1???????: CUR_ADDR <= sync3.dat[6:0];
                        8'b00001???: DISP_ON  <= sync3.dat[2];
                        8'b000001??: inc      <= sync3.dat[1];
                        8'b0000001?: CUR_ADDR <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Lines map to 0x00-0x0F and 0x40-0x4F; everything else is invisible
    always_comb begin
        mem_we   = 1'b0;
        mem_idx  = {CUR_ADDR[6], CUR_ADDR[3:0]};
        mem_wdat = sync3.dat;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_idx  = cnt[4:0];
            mem_wdat = 8'h20;
        end else if (accept && sync3.rs && CUR_ADDR[5:4] == 2'b00) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) shadow[mem_idx] <= mem_wdat;
        RD_DATA <= shadow[RD_ADDR];
    end

`ifdef LCD_RX_OVERRUN_EN
    logic overrun;
    always_ff @(posedge CLK) begin
        if (RESETN)                           overrun <= 1'b0;
        else if (strobe & BUSY & ~sync3.rw)   overrun <= 1'b1;
    end
    assign OVERRUN = overrun;
`else
    assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_char_rx.sv
// Directed bench for lcd_char_rx: clear, writes, address wrap, busy boundary, overrun, reset abort.
module tb_lcd_char_rx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_valid, cmd_rs;
    logic [7:0] cmd_code;
    logic       busy, disp_on, overrun;
    logic [6:0] cur_addr;

    always #5 clk = ~clk;

`ifdef LCD_RX_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    lcd_char_rx #(.BUSY_CYCLES(40)) dut (
        .CLK(clk), .RESETN(resetn),
        .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .CMD_VALID(cmd_valid), .CMD_RS(cmd_rs), .CMD_CODE(cmd_code),
        .BUSY(busy), .DISP_ON(disp_on), .CUR_ADDR(cur_addr), .OVERRUN(overrun)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_mem [32];
    logic       got, seen;
    int         lat, n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e    = 1'b0;
    endtask

    // Returns at the sample where CMD_VALID is seen, or after 8 cycles
    task automatic send(input logic rs, input logic rw, input logic [7:0] d,
                        output logic g, output int l);
        pulse(rs, rw, d);
        g = 1'b0;
        l = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                g = 1'b1;
                l = i;
                break;
            end
        end
    endtask

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input int exp_busy);
        logic g;
        int   l, b;
        send(rs, 1'b0, d, g, l);
        chk("cmd_valid", g, 1);
        chk("cmd_rs", cmd_rs, rs);
        chk("cmd_code", cmd_code, d);
        busy_len(b);
        chk("busy_len", b, exp_busy);
    endtask

    task automatic poll_quiet(output logic s);
        s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) s = 1'b1;
        end
    endtask

    task automatic rd_all();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("rd[%0d]", i), rd_data, exp_mem[i]);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cur_addr", cur_addr, 7'h00);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_rs", cmd_rs, 0);
        chk("rst_cmd_code", cmd_code, 8'h00);
        chk("rst_disp_on", disp_on, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 1);
        resetn = 1'b0;
        busy_len(n);
        chk("clr_busy_len", n, 32);
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        chk("clr_cur_addr", cur_addr, 7'h00);
        rd_all();
    endtask

    initial begin
        resetn   = 1'b1;
        lcd_e    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 5'd0;
        @(negedge clk);
        do_reset();

        // Line 1 writes and first-strobe latency
        send(1'b0, 1'b0, 8'h80, got, lat);
        chk("lat_valid", got, 1);
        chk("lat_cycles", lat, 3);
        busy_len(n);
        chk("busy_80", n, 40);
        wr(1'b1, 8'h48, 40);
        wr(1'b1, 8'h49, 40);
        exp_mem[0] = 8'h48;
        exp_mem[1] = 8'h49;
        chk("addr_after_hi", cur_addr, 7'h02);

        // Line 2 fill, then one byte past the visible window
        wr(1'b0, 8'hC0, 40);
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 8'(8'h41 + i), 40);
            exp_mem[16 + i] = 8'(8'h41 + i);
        end
        chk("addr_line2_end", cur_addr, 7'h50);
        wr(1'b1, 8'h51, 40);
        chk("addr_past_end", cur_addr, 7'h51);
        rd_all();

        // Wrap points in both directions
        wr(1'b0, 8'hA7, 40);
        chk("addr_a7", cur_addr, 7'h27);
        wr(1'b1, 8'h5A, 40);
        chk("wrap_27_40", cur_addr, 7'h40);
        wr(1'b0, 8'h04, 40);
        chk("entry_keep_addr", cur_addr, 7'h40);
        wr(1'b0, 8'h80, 40);
        chk("addr_00", cur_addr, 7'h00);
        wr(1'b1, 8'h33, 40);
        exp_mem[0] = 8'h33;
        chk("wrap_00_67", cur_addr, 7'h67);
        rd_all();

        // Strobe while busy
        send(1'b0, 1'b0, 8'h0C, got, lat);
        chk("ovr_first_valid", got, 1);
        repeat (6) @(negedge clk);
        pulse(1'b0, 1'b0, 8'h08);
        poll_quiet(seen);
        chk("ovr_drop_valid", seen, 0);
        chk("ovr_flag", overrun, OVR_EN);
        chk("ovr_disp_on", disp_on, 1);
        busy_len(n);

        // Display off, then a read strobe
        wr(1'b0, 8'h08, 40);
        chk("disp_off", disp_on, 0);
        send(1'b0, 1'b1, 8'h0C, got, lat);
        chk("rw_no_valid", got, 0);
        chk("rw_no_busy", busy, 0);
        chk("rw_disp_on", disp_on, 0);
        chk("ovr_sticky", overrun, OVR_EN);

        // Strobe acted on in the last busy cycle is dropped
        send(1'b0, 1'b0, 8'h08, got, lat);
        chk("edge1_valid", got, 1);
        lcd_rs   = 1'b0;
        lcd_data = 8'h0C;
        repeat (30) @(negedge clk);
        lcd_e = 1'b1;
        repeat (7) @(negedge clk);
        lcd_e = 1'b0;
        poll_quiet(seen);
        chk("last_busy_drop", seen, 0);
        chk("last_busy_disp", disp_on, 0);
        chk("last_busy_idle", busy, 0);

        // One cycle later it lands on the first idle cycle
        send(1'b0, 1'b0, 8'h08, got, lat);
        chk("edge2_valid", got, 1);
        lcd_rs   = 1'b0;
        lcd_data = 8'h0C;
        repeat (31) @(negedge clk);
        lcd_e = 1'b1;
        repeat (7) @(negedge clk);
        lcd_e = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) seen = 1'b1;
        end
        chk("first_idle_accept", seen, 1);
        chk("first_idle_disp", disp_on, 1);
        busy_len(n);

        // Clear instruction restores blanks, address 0 and increment
        wr(1'b0, 8'h01, 32);
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        chk("clr_instr_addr", cur_addr, 7'h00);
        wr(1'b1, 8'h77, 40);
        exp_mem[0] = 8'h77;
        chk("clr_inc_restored", cur_addr, 7'h01);
        rd_all();

        // Reset in the middle of EXEC
        send(1'b0, 1'b0, 8'h0C, got, lat);
        chk("pre_reset_valid", got, 1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
